mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle sequencer for the MIPS datapath. Accepts one instruction at a time
//  (opcode/funct) and steps it through DECODE, EXEC, MEM and WB/BR states. In each
//  state it drives the datapath strobes (regWrite, memRead, memWrite, branch,
//  aluControl, pc_write). Memory handshakes on mem_ready with a timeout.
//  Retired instructions are counted.
// PARAMETERS
//  MEM_TIMEOUT  16  max MEM-state cycles waiting for mem_ready before abort (>=1)
//  COUNT_W      16  width of retired-instruction counter
// PORTS
//  clk          in   1        single clock, rising edge
//  reset        in   1        reset, asynchronous, active-low (0 = reset)
//  instr_valid  in   1        opcode/funct valid this cycle
//  instr_ready  out  1        controller idle, will accept instruction
//  opcode       in   6        instruction[31:26]
//  funct        in   6        instruction[5:0]
//  zero         in   1        ALU zero flag (used only for taken_count)
//  mem_ready    in   1        data memory access complete
//  regWrite     out  1        register file write strobe
//  memRead      out  1        data memory read enable
//  memWrite     out  1        data memory write strobe
//  branch       out  1        branch qualifier to PC mux
//  aluControl   out  3        010 ADD, 110 SUB, 000 AND, 001 OR
//  pc_write     out  1        PC update enable, 1 cycle per retired instr
//  illegal      out  1        1-cycle pulse: unsupported opcode/funct
//  mem_error    out  1        1-cycle pulse: MEM timeout abort
//  instr_count  out  COUNT_W  retired instructions, wraps to 0
//  taken_count  out  COUNT_W  taken branches (branch state with zero=1), wraps
// BEHAVIOUR
//  Reset: One clock; reset is asynchronous and active-low.
//   While reset=0: state=IDLE. All outputs are 0, including instr_ready and both counters.
//   Assertion mid-instruction aborts it immediately, with no pc_write.
//  IDLE:
//   instr_ready=1. instr_valid=1 captures opcode/funct into registers -> DECODE.
//  DECODE:
//   R-type (op 000000) with funct 100000/100010/100100/100101 -> ADD/SUB/AND/OR.
//   LW (100011) and SW (101011) -> ADD. BEQ (000100) -> SUB.
//   Any other opcode/funct -> illegal=1 for this cycle, then IDLE. Nothing is retired.
//   aluControl is set on entry to DECODE and held until return to IDLE (000 in IDLE).
//  EXEC:
//   1 cycle. R-type -> WB. LW/SW -> MEM. BEQ -> BR.
//  MEM:
//   LW holds memRead=1; SW holds memWrite=1. Both are held until mem_ready=1 is sampled.
//   mem_ready=1 -> WB (memRead/memWrite drop on exit).
//   Wait counter starts at 0 on entry. After MEM_TIMEOUT cycles with mem_ready=0:
//    mem_error=1 for 1 cycle, then IDLE. No pc_write; nothing counted.
//   mem_ready outside MEM is ignored.
//  WB:
//   1 cycle, pc_write=1. regWrite=1 for R-type and LW only. instr_count += 1.
//  BR:
//   1 cycle, branch=1, pc_write=1. instr_count += 1. taken_count += 1 if zero=1.
//  Latency (accept cycle = 0):
//   R-type retires in cycle 3 and is back in IDLE at cycle 4. BEQ has the same timing.
//   LW/SW retire in cycle 3+N, where N = MEM cycles (1..MEM_TIMEOUT).
//  Counters wrap all-ones -> 0 without a flag.
//  instr_valid outside IDLE is ignored; the captured opcode is stable per instruction.
//  Strobes are mutually exclusive: at most one of regWrite/memRead/memWrite/branch is high per cycle.
// TESTING
//  1 ADD: op 0, funct 100000 -> aluControl=010 cycles 1-3; regWrite=pc_write=1 in cycle 3 only; count=1.
//  2 LW with mem_ready high in 3rd MEM cycle -> memRead=1 for 3 cycles; regWrite at cycle 6; count=1.
//  3 SW, MEM_TIMEOUT=4, mem_ready stuck 0 -> memWrite 4 cycles; mem_error pulse; no pc_write; count=0.
//  4 BEQ with zero=1 then BEQ with zero=0 -> branch=1 once each; taken_count=1; instr_count=2.
//  5 opcode 111111 -> illegal pulse in cycle 1; back in IDLE at cycle 2; no strobes.
//  6 reset=0 during MEM of LW -> memRead=0 asynchronously; state IDLE; counters 0; instr_ready=1 after release.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control sequencer: steps one instruction at a time through
// DECODE/EXEC/MEM/WB/BR and drives registered datapath strobes plus retire counters.
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               regWrite,
    output logic               memRead,
    output logic               memWrite,
    output logic               branch,
    output logic [2:0]         aluControl,
    output logic               pc_write,
    output logic               illegal,
    output logic               mem_error,
    output logic [COUNT_W-1:0] instr_count,
    output logic [COUNT_W-1:0] taken_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR, S_ERR
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_LW, C_SW, C_BEQ, C_ILL
    } cls_t;

    state_t            state_q, state_d;
    cls_t              cls_q, dec_cls, cls_d;
    logic [2:0]        alu_q, dec_alu, alu_d;
    logic [WAIT_W-1:0] wait_q;
    logic              accept;

    logic instr_ready_d, reg_write_d, mem_read_d, mem_write_d, branch_d;
    logic pc_write_d, illegal_d, mem_error_d;
    logic [2:0] alu_ctl_d;

    // instr_ready is high exactly in IDLE once out of reset, so it gates capture
    assign accept = instr_valid & instr_ready;

    // Instruction class and ALU operation of the presented opcode/funct
    always_comb begin
        dec_cls = C_ILL;
        dec_alu = ALU_AND;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: begin dec_cls = C_R; dec_alu = ALU_ADD; end
                    6'b100010: begin dec_cls = C_R; dec_alu = ALU_SUB; end
                    6'b100100: begin dec_cls = C_R; dec_alu = ALU_AND; end
                    6'b100101: begin dec_cls = C_R; dec_alu = ALU_OR;  end
                    default:   begin dec_cls = C_ILL; dec_alu = ALU_AND; end
                endcase
            end
            6'b100011: begin dec_cls = C_LW;  dec_alu = ALU_ADD; end
            6'b101011: begin dec_cls = C_SW;  dec_alu = ALU_ADD; end
            6'b000100: begin dec_cls = C_BEQ; dec_alu = ALU_SUB; end
            default:   begin dec_cls = C_ILL; dec_alu = ALU_AND; end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_DECODE;
            S_DECODE: state_d = (cls_q == C_ILL) ? S_IDLE : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    C_LW, C_SW: state_d = S_MEM;
                    C_BEQ:      state_d = S_BR;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready)               state_d = S_WB;
                else if (wait_q == WAIT_LAST) state_d = S_ERR;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so the registered strobes align with it
    always_comb begin
        cls_d         = accept ? dec_cls : cls_q;
        alu_d         = accept ? dec_alu : alu_q;
        instr_ready_d = (state_d == S_IDLE);
        alu_ctl_d     = (state_d == S_IDLE) ? ALU_AND : alu_d;
        reg_write_d   = 1'b0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        branch_d      = 1'b0;
        pc_write_d    = 1'b0;
        illegal_d     = 1'b0;
        mem_error_d   = 1'b0;
        case (state_d)
            S_DECODE: illegal_d   = (cls_d == C_ILL);
            S_MEM: begin
                mem_read_d  = (cls_d == C_LW);
                mem_write_d = (cls_d == C_SW);
            end
            S_WB: begin
                reg_write_d = (cls_d == C_R) || (cls_d == C_LW);
                pc_write_d  = 1'b1;
            end
            S_BR: begin
                branch_d    = 1'b1;
                pc_write_d  = 1'b1;
            end
            S_ERR:    mem_error_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_ready <= 1'b0;
            regWrite    <= 1'b0;
            memRead     <= 1'b0;
            memWrite    <= 1'b0;
            branch      <= 1'b0;
            aluControl  <= 3'b000;
            pc_write    <= 1'b0;
            illegal     <= 1'b0;
            mem_error   <= 1'b0;
        end else begin
            instr_ready <= instr_ready_d;
            regWrite    <= reg_write_d;
            memRead     <= mem_read_d;
            memWrite    <= mem_write_d;
            branch      <= branch_d;
            aluControl  <= alu_ctl_d;
            pc_write    <= pc_write_d;
            illegal     <= illegal_d;
            mem_error   <= mem_error_d;
        end
    end

    // Captured instruction, MEM wait counter and retire counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cls_q       <= C_ILL;
            alu_q       <= ALU_AND;
            wait_q      <= '0;
            instr_count <= '0;
            taken_count <= '0;
        end else begin
            if (accept) begin
                cls_q <= dec_cls;
                alu_q <= dec_alu;
            end
            wait_q <= (state_q == S_MEM) ? wait_q + WAIT_W'(1) : '0;
            if (state_q == S_WB || state_q == S_BR)
                instr_count <= instr_count + COUNT_W'(1);
            if (state_q == S_BR && zero)
                taken_count <= taken_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a latency-based per-instruction model
// predicts every output each cycle; a few literal checks pin the model.
module tb_mips_multicycle_ctrl;

    localparam int T    = 4;
    localparam int CW   = 4;
    localparam int WRAP = 1 << CW;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ILL = 4;

    logic          clk, reset, instr_valid, instr_ready, zero, mem_ready;
    logic [5:0]    opcode, funct;
    logic          regWrite, memRead, memWrite, branch, pc_write, illegal, mem_error;
    logic [2:0]    aluControl;
    logic [CW-1:0] instr_count, taken_count;
    logic [10:0]   act_vec, exp_vec;

    int total = 0;
    int bad   = 0;
    int exp_icnt = 0;
    int exp_tcnt = 0;
    int cur_k = 0;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(T), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite), .branch(branch),
        .aluControl(aluControl), .pc_write(pc_write), .illegal(illegal),
        .mem_error(mem_error), .instr_count(instr_count), .taken_count(taken_count)
    );

    assign act_vec = {instr_ready, regWrite, memRead, memWrite, branch,
                      aluControl, pc_write, illegal, mem_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s k=%0d got=%0h want=%0h", name, cur_k, got, want);
        end
    endtask

    task automatic check_cycle();
        check("outs", 32'(act_vec), 32'(exp_vec));
        check("instr_count", 32'(instr_count), 32'(exp_icnt % WRAP));
        check("taken_count", 32'(taken_count), 32'(exp_tcnt % WRAP));
    endtask

    // One instruction from accept (cycle 0) until the first idle cycle after it
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int kind,
                             input logic [2:0] alu, input int n_ready, input bit zero_v);
        int  last, retire, err, mem_hi;
        bit  mem_k, ok, active;
        mem_k  = (kind == K_LW) || (kind == K_SW);
        ok     = (n_ready >= 1) && (n_ready <= T);
        retire = -1;
        err    = -1;
        mem_hi = ok ? 2 + n_ready : 2 + T;
        if (kind == K_ILL)  last = 1;
        else if (!mem_k)    begin last = 3; retire = 3; end
        else if (ok)        begin last = 3 + n_ready; retire = last; end
        else                begin last = 3 + T; err = last; end
        for (int k = 0; k <= last + 1; k++) begin
            @(posedge clk); #2;
            cur_k       = k;
            instr_valid = (k <= last);
            opcode      = (k == 0) ? op : 6'h3f;
            funct       = (k == 0) ? fn : 6'h2a;
            zero        = (kind == K_BEQ && k == 3) ? zero_v : ~zero_v;
            if (!mem_k)  mem_ready = 1'b1;
            else if (ok) mem_ready = (k <= 2) || (k >= 2 + n_ready);
            else         mem_ready = (k <= 2) || (k > 2 + T);
            if (k == last + 1 && retire > 0) begin
                exp_icnt++;
                if (kind == K_BEQ && zero_v) exp_tcnt++;
            end
            active  = (k >= 1) && (k <= last);
            exp_vec = {!active,
                       k == retire && (kind == K_R || kind == K_LW),
                       kind == K_LW && k >= 3 && k <= mem_hi,
                       kind == K_SW && k >= 3 && k <= mem_hi,
                       k == retire && kind == K_BEQ,
                       active ? alu : 3'b000,
                       k == retire,
                       kind == K_ILL && k == 1,
                       k == err};
            @(negedge clk);
            check_cycle();
        end
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; opcode = '0; funct = '0;
        zero = 1'b0; mem_ready = 1'b0;
        #3 reset = 1'b0;
        #3;
        check("reset outs", 32'(act_vec), 32'd0);
        check("reset icnt", 32'(instr_count), 32'd0);
        check("reset tcnt", 32'(taken_count), 32'd0);
        @(posedge clk); #2 reset = 1'b1;

        run_instr(6'b000000, 6'b100000, K_R, 3'b010, 0, 1'b0);
        check("pin add count", 32'(instr_count), 32'd1);
        run_instr(6'b100011, 6'b000000, K_LW, 3'b010, 3, 1'b0);
        run_instr(6'b101011, 6'b000000, K_SW, 3'b010, 0, 1'b0);
        check("pin sw timeout count", 32'(instr_count), 32'd2);
        run_instr(6'b000100, 6'b000000, K_BEQ, 3'b110, 0, 1'b1);
        run_instr(6'b000100, 6'b000000, K_BEQ, 3'b110, 0, 1'b0);
        check("pin taken", 32'(taken_count), 32'd1);
        check("pin beq count", 32'(instr_count), 32'd4);
        run_instr(6'b111111, 6'b000000, K_ILL, 3'b000, 0, 1'b0);
        run_instr(6'b000000, 6'b101010, K_ILL, 3'b000, 0, 1'b0);
        run_instr(6'b000000, 6'b100010, K_R, 3'b110, 0, 1'b0);
        run_instr(6'b000000, 6'b100100, K_R, 3'b000, 0, 1'b1);
        run_instr(6'b000000, 6'b100101, K_R, 3'b001, 0, 1'b0);
        run_instr(6'b100011, 6'b000000, K_LW, 3'b010, T, 1'b0);
        run_instr(6'b101011, 6'b000000, K_SW, 3'b010, 1, 1'b1);
        for (int i = 0; i < 8; i++)
            run_instr(6'b000000, 6'b100101, K_R, 3'b001, 0, 1'b0);
        check("pin wrap count", 32'(instr_count), 32'd1);

        // Reset asserted while an LW waits in MEM
        @(posedge clk); #2;
        cur_k = 0; opcode = 6'b100011; funct = 6'b0; instr_valid = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #2 instr_valid = 1'b0; cur_k = 1;
        @(posedge clk); #2 cur_k = 2;
        @(posedge clk); #2 cur_k = 3;
        @(negedge clk);
        check("pre-reset memRead", 32'(memRead), 32'd1);
        @(posedge clk); #2 cur_k = 4; reset = 1'b0;
        #1;
        check("async reset outs", 32'(act_vec), 32'd0);
        check("async reset icnt", 32'(instr_count), 32'd0);
        check("async reset tcnt", 32'(taken_count), 32'd0);
        exp_icnt = 0;
        exp_tcnt = 0;
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2;
        @(negedge clk);
        check("ready after release", 32'(instr_ready), 32'd1);
        run_instr(6'b000000, 6'b100000, K_R, 3'b010, 0, 1'b0);
        check("pin post-reset count", 32'(instr_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
